// File: rtl/angle_frame_pkg.sv
// Shared encodings and constants for the angle frame receiver.
// Frame layout: byte 1 = {id[3:0], angle[11:8]}, byte 2 = angle[7:0].
package angle_frame_pkg;

   localparam int unsigned ID_W    = 4;
   localparam int unsigned ANGLE_W = 12;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [ID_W-1:0]   BCAST_ID = 4'hF;
   localparam logic [BYTE_W-1:0] ACK_BASE = 8'hA0;
   localparam logic [BYTE_W-1:0] ERR_MAX  = 8'd255;

   typedef enum logic {
      IDLE,
      WAIT_LSB
   } rx_state_e;

   typedef enum logic [1:0] {
      A_IDLE,
      A_WAIT,
      A_SEND
   } ack_state_e;

   typedef struct packed {
      logic [ID_W-1:0]    id;
      logic [ANGLE_W-1:0] angle;
   } frame_t;

   function automatic frame_t decode_frame(input logic [BYTE_W-1:0] msb,
                                           input logic [BYTE_W-1:0] lsb);
      frame_t f;
      f.id    = msb[7:4];
      f.angle = {msb[3:0], lsb};
      return f;
   endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and flags
// when TIMEOUT_CYCLES of them have elapsed.
module frame_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 24000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Expiry is seen during the last permitted cycle so the owner can act on it.
   assign expired = enable && !clear && (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/angle_frame_ctrl.sv
// Two-byte angle frame receiver with shadowed, sync-aligned angle update.
// Define FRAME_ACK_EN to transmit an ACK byte for each addressed frame.
module angle_frame_ctrl
   import angle_frame_pkg::*;
#(
   parameter logic [3:0]  MODULE_ID      = 4'h0,
   parameter int unsigned TIMEOUT_CYCLES = 24000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [BYTE_W-1:0]   data_received,
   input  logic                rx_done,
   input  logic                parity_error,
   input  logic                sync_pulse,
   input  logic                tx_busy,
   output logic                start_tx,
   output logic [BYTE_W-1:0]   data_to_tx,
   output logic [ANGLE_W-1:0]  angle,
   output logic                angle_valid,
   output logic [BYTE_W-1:0]   err_count
);

   rx_state_e           state_q, state_d;
   logic [BYTE_W-1:0]   msb_q, msb_d;
   logic [ANGLE_W-1:0]  shadow_q, shadow_d;
   logic                pending_q, pending_d;
   logic [ANGLE_W-1:0]  angle_q, angle_d;
   logic                angle_valid_q, angle_valid_d;
   logic [BYTE_W-1:0]   err_q, err_d;

   logic   clean_rx, bad_rx, accept, frame_err, tmo_clear, tmo_expired;
   frame_t frm;

   assign clean_rx = rx_done && !parity_error;
   assign bad_rx   = rx_done && parity_error;
   assign frm      = decode_frame(msb_q, data_received);

   frame_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (state_q == WAIT_LSB),
      .expired(tmo_expired)
   );

   always_comb begin
      state_d       = state_q;
      msb_d         = msb_q;
      shadow_d      = shadow_q;
      pending_d     = pending_q;
      angle_d       = angle_q;
      angle_valid_d = angle_valid_q;
      err_d         = err_q;
      accept        = 1'b0;
      frame_err     = 1'b0;
      tmo_clear     = 1'b0;

      case (state_q)
         IDLE: begin
            if (clean_rx) begin
               msb_d     = data_received;
               state_d   = WAIT_LSB;
               tmo_clear = 1'b1;
            end else if (bad_rx) begin
               frame_err = 1'b1;
            end
         end
         WAIT_LSB: begin
            if (bad_rx) begin
               frame_err = 1'b1;
               state_d   = IDLE;
            end else if (clean_rx) begin
               state_d = IDLE;
               accept  = (frm.id == MODULE_ID) || (frm.id == BCAST_ID);
            end else if (tmo_expired) begin
               frame_err = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Sync consumes the old shadow first; a same-cycle accept re-arms pending.
      if (sync_pulse && pending_q) begin
         angle_d       = shadow_q;
         angle_valid_d = 1'b1;
         pending_d     = 1'b0;
      end
      if (accept) begin
         shadow_d  = frm.angle;
         pending_d = 1'b1;
      end

      if (frame_err && (err_q != ERR_MAX)) begin
         err_d = err_q + BYTE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         msb_q         <= '0;
         shadow_q      <= '0;
         pending_q     <= 1'b0;
         angle_q       <= '0;
         angle_valid_q <= 1'b0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         msb_q         <= msb_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         angle_q       <= angle_d;
         angle_valid_q <= angle_valid_d;
         err_q         <= err_d;
      end
   end

   assign angle       = angle_q;
   assign angle_valid = angle_valid_q;
   assign err_count   = err_q;

`ifdef FRAME_ACK_EN
   ack_state_e         ack_q, ack_d;
   logic               start_tx_q, start_tx_d;
   logic [BYTE_W-1:0]  data_to_tx_q, data_to_tx_d;
   logic               ack_req;

   assign ack_req = accept && (frm.id != BCAST_ID);

   // Requests arriving while an ACK is already queued merge into it.
   always_comb begin
      ack_d        = ack_q;
      start_tx_d   = 1'b0;
      data_to_tx_d = data_to_tx_q;
      case (ack_q)
         A_IDLE: if (ack_req) ack_d = A_WAIT;
         A_WAIT: begin
            if (!tx_busy) begin
               ack_d        = A_SEND;
               start_tx_d   = 1'b1;
               data_to_tx_d = ACK_BASE | {4'h0, MODULE_ID};
            end
         end
         A_SEND: ack_d = ack_req ? A_WAIT : A_IDLE;
         default: ack_d = A_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_q        <= A_IDLE;
         start_tx_q   <= 1'b0;
         data_to_tx_q <= '0;
      end else begin
         ack_q        <= ack_d;
         start_tx_q   <= start_tx_d;
         data_to_tx_q <= data_to_tx_d;
      end
   end

   assign start_tx   = start_tx_q;
   assign data_to_tx = data_to_tx_q;
`else
   logic unused_tx_busy;
   assign unused_tx_busy = tx_busy;
   assign start_tx       = 1'b0;
   assign data_to_tx     = '0;
`endif

endmodule

// File: tb/tb_angle_frame_ctrl.sv
// Directed bench for angle_frame_ctrl (MODULE_ID=2, default timeout).
// Builds with or without FRAME_ACK_EN.
module tb_angle_frame_ctrl;

   localparam int unsigned TMO = 24000;
`ifdef FRAME_ACK_EN
   localparam int ACK_N = 1;
   localparam logic [7:0] ACK_BYTE = 8'hA2;
`else
   localparam int ACK_N = 0;
   localparam logic [7:0] ACK_BYTE = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  data_received;
   logic        rx_done;
   logic        parity_error;
   logic        sync_pulse;
   logic        tx_busy;
   logic        start_tx;
   logic [7:0]  data_to_tx;
   logic [11:0] angle;
   logic        angle_valid;
   logic [7:0]  err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int st_cnt  = 0;
   int st_base;
   logic [7:0] last_ack = 8'h00;

   angle_frame_ctrl #(
      .MODULE_ID     (4'h2),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_received(data_received),
      .rx_done      (rx_done),
      .parity_error (parity_error),
      .sync_pulse   (sync_pulse),
      .tx_busy      (tx_busy),
      .start_tx     (start_tx),
      .data_to_tx   (data_to_tx),
      .angle        (angle),
      .angle_valid  (angle_valid),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start_tx) begin
         st_cnt   <= st_cnt + 1;
         last_ack <= data_to_tx;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic pe = 1'b0, input logic sy = 1'b0);
      @(posedge clk);
      #1;
      data_received = b;
      rx_done       = 1'b1;
      parity_error  = pe;
      sync_pulse    = sy;
      @(posedge clk);
      #1;
      rx_done       = 1'b0;
      parity_error  = 1'b0;
      sync_pulse    = 1'b0;
   endtask

   task automatic do_sync();
      @(posedge clk);
      #1;
      sync_pulse = 1'b1;
      @(posedge clk);
      #1;
      sync_pulse = 1'b0;
   endtask

   initial begin
      reset = 1'b0; data_received = 8'h00; rx_done = 1'b0;
      parity_error = 1'b0; sync_pulse = 1'b0; tx_busy = 1'b0;
      tick(3);
      chk("rst_angle", angle, 0);
      chk("rst_valid", angle_valid, 0);
      chk("rst_err", err_count, 0);
      chk("rst_start_tx", start_tx, 0);
      chk("rst_data_tx", data_to_tx, 0);
      @(negedge clk) reset = 1'b1;
      tick(2);

      // Addressed frame with transmitter busy, then sync.
      st_base = st_cnt;
      tx_busy = 1'b1;
      send_byte(8'h21);
      send_byte(8'h34);
      tick(4);
      chk("ack_held_busy", st_cnt - st_base, 0);
      tx_busy = 1'b0;
      tick(4);
      chk("ack_count", st_cnt - st_base, ACK_N);
      chk("ack_byte", (ACK_N != 0) ? last_ack : data_to_tx, ACK_BYTE);
      @(posedge clk);
      #1 sync_pulse = 1'b1;
      #3 chk("angle_pre_sync", angle, 12'h000);
      @(posedge clk);
      #1 sync_pulse = 1'b0;
      chk("angle_134", angle, 12'h134);
      chk("valid_134", angle_valid, 1);

      // Broadcast frame: applied, never acknowledged.
      st_base = st_cnt;
      send_byte(8'hF5);
      send_byte(8'h67);
      tick(3);
      do_sync();
      chk("angle_567", angle, 12'h567);
      chk("bcast_no_ack", st_cnt - st_base, 0);

      // Sync with nothing pending leaves the angle alone.
      do_sync();
      chk("idle_sync_hold", angle, 12'h567);

      // Timeout between MSB and LSB, checked on both sides of the limit.
      send_byte(8'h21);
      tick(TMO - 1);
      chk("tmo_not_yet", err_count, 0);
      tick(1);
      chk("tmo_err", err_count, 1);
      send_byte(8'h2A);
      send_byte(8'hBC);
      do_sync();
      chk("angle_abc", angle, 12'hABC);

      // Two frames before sync: the last one wins.
      send_byte(8'h21); send_byte(8'h00);
      send_byte(8'h22); send_byte(8'h00);
      do_sync();
      chk("last_wins", angle, 12'h200);

      // Accept on the same cycle as sync: old shadow applied, new waits.
      send_byte(8'h21); send_byte(8'h11);
      send_byte(8'h23); send_byte(8'h45, 1'b0, 1'b1);
      chk("same_cycle_old", angle, 12'h111);
      do_sync();
      chk("same_cycle_new", angle, 12'h345);

      // Foreign ID: dropped silently.
      send_byte(8'h35); send_byte(8'h99);
      do_sync();
      chk("foreign_angle", angle, 12'h345);
      chk("foreign_no_err", err_count, 1);

      // Corrupt LSBs saturate the error counter.
      for (int i = 0; i < 300; i++) begin
         send_byte(8'h21);
         send_byte(8'h77, 1'b1);
      end
      chk("err_sat", err_count, 255);
      do_sync();
      chk("parity_angle", angle, 12'h345);

      // Reset mid-frame clears everything immediately.
      send_byte(8'h21);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_angle", angle, 0);
      chk("mid_rst_valid", angle_valid, 0);
      chk("mid_rst_err", err_count, 0);
      chk("mid_rst_start_tx", start_tx, 0);
      chk("mid_rst_data_tx", data_to_tx, 0);
      @(negedge clk) reset = 1'b1;
      send_byte(8'h21);
      send_byte(8'h23);
      do_sync();
      chk("post_rst_angle", angle, 12'h123);
      chk("post_rst_valid", angle_valid, 1);
      chk("post_rst_err", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
